rv_timer_mc: RTL and testbench

RV_TIMER_MC -- requirements
Module: rv_timer_mc

---
 rtl/rv_timer_mc.sv | 122 ++++++++++++
 tb/tb_rv_timer_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_timer_mc.sv
// rv_timer_mc: RISC-V style machine timer with N_CH independent compare channels.
// A prescaler produces tick_o; mtime advances by step_i on each tick and may be loaded
// directly. Each channel compares mtime against its cmp register in one of the modes
// off / level / one-shot / periodic, and raises a raw interrupt bit in intr_state_o.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   active_i, prescaler_i, step_i timer enable, tick divider, per-tick increment
//   mtime_we_i, mtime_wdata_i     mtime load
//   mtime_o, tick_o               mtime register, prescaler tick (combinational)
//   cmp_we_i, cmp_wdata_i, cmp_o  per-channel compare writes (shared data), compare registers
//   mode_i, period_i              per-channel mode and periodic reload increment
//   intr_en_i, intr_clr_i         interrupt mask, write-1-to-clear pulses
//   intr_state_o, intr_o          raw interrupt status, masked interrupt (combinational)
module rv_timer_mc #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned PRESC_W = 12,
  parameter int unsigned STEP_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    active_i,
  input  logic [PRESC_W-1:0]      prescaler_i,
  input  logic [STEP_W-1:0]       step_i,
  input  logic                    mtime_we_i,
  input  logic [CNT_W-1:0]        mtime_wdata_i,
  output logic [CNT_W-1:0]        mtime_o,
  output logic                    tick_o,
  input  logic [N_CH-1:0]         cmp_we_i,
  input  logic [CNT_W-1:0]        cmp_wdata_i,
  output logic [N_CH*CNT_W-1:0]   cmp_o,
  input  logic [2*N_CH-1:0]       mode_i,
  input  logic [N_CH*CNT_W-1:0]   period_i,
  input  logic [N_CH-1:0]         intr_en_i,
  input  logic [N_CH-1:0]         intr_clr_i,
  output logic [N_CH-1:0]         intr_state_o,
  output logic [N_CH-1:0]         intr_o
);

  localparam int unsigned CMP_W = N_CH * CNT_W;

  localparam logic [1:0] MODE_LEVEL    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_PERIODIC = 2'b11;

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   mtime_q, mtime_d;
  logic [CMP_W-1:0]   cmp_q, cmp_d;
  logic [N_CH-1:0]    armed_q, armed_d;
  logic [N_CH-1:0]    intr_state_q, intr_state_d;
  logic [N_CH-1:0]    hit_c;

  // ">=" rather than "==" so lowering prescaler_i below the count still wraps.
  assign tick_o       = active_i & (cnt_q >= prescaler_i);
  assign mtime_o      = mtime_q;
  assign cmp_o        = cmp_q;
  assign intr_state_o = intr_state_q;
  assign intr_o       = intr_state_q & intr_en_i;

  // Per-channel compare against registered mtime and cmp only.
  always_comb begin : hit_calc
    hit_c = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      hit_c[c] = active_i && (mode_i[2*c +: 2] != 2'b00) &&
                 (mtime_q >= cmp_q[c*CNT_W +: CNT_W]);
    end
  end

  // Next-state for prescaler, mtime and all channels.
  always_comb begin : next_state
    cnt_d        = cnt_q;
    mtime_d      = mtime_q;
    cmp_d        = cmp_q;
    armed_d      = armed_q;
    intr_state_d = intr_state_q;

    if (!active_i || tick_o) cnt_d = '0;
    else                     cnt_d = cnt_q + PRESC_W'(1);

    if (mtime_we_i)  mtime_d = mtime_wdata_i;
    else if (tick_o) mtime_d = mtime_q + CNT_W'(step_i);

    for (int c = 0; c < int'(N_CH); c++) begin
      case (mode_i[2*c +: 2])
        MODE_LEVEL: intr_state_d[c] = hit_c[c];
        MODE_ONESHOT: begin
          if (hit_c[c] && armed_q[c]) armed_d[c] = 1'b0;
          // Set beats clear when both land on the same cycle.
          intr_state_d[c] = (hit_c[c] & armed_q[c]) | (intr_state_q[c] & ~intr_clr_i[c]);
        end
        MODE_PERIODIC: begin
          if (hit_c[c]) cmp_d[c*CNT_W +: CNT_W] = cmp_q[c*CNT_W +: CNT_W] + period_i[c*CNT_W +: CNT_W];
          intr_state_d[c] = hit_c[c] | (intr_state_q[c] & ~intr_clr_i[c]);
        end
        default: intr_state_d[c] = intr_state_q[c] & ~intr_clr_i[c];
      endcase
      // Software write overrides any reload and re-arms the channel.
      if (cmp_we_i[c]) begin
        cmp_d[c*CNT_W +: CNT_W] = cmp_wdata_i;
        armed_d[c]              = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin : regs
    if (rst_i) begin
      cnt_q        <= '0;
      mtime_q      <= '0;
      cmp_q        <= '1;
      armed_q      <= '1;
      intr_state_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      mtime_q      <= mtime_d;
      cmp_q        <= cmp_d;
      armed_q      <= armed_d;
      intr_state_q <= intr_state_d;
    end
  end

endmodule

// File: tb/tb_rv_timer_mc.sv
// Directed testbench for rv_timer_mc with N_CH=2, CNT_W=64.
module tb_rv_timer_mc;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         active_i;
  logic [11:0]  prescaler_i;
  logic [7:0]   step_i;
  logic         mtime_we_i;
  logic [63:0]  mtime_wdata_i;
  logic [63:0]  mtime_o;
  logic         tick_o;
  logic [1:0]   cmp_we_i;
  logic [63:0]  cmp_wdata_i;
  logic [127:0] cmp_o;
  logic [3:0]   mode_i;
  logic [127:0] period_i;
  logic [1:0]   intr_en_i;
  logic [1:0]   intr_clr_i;
  logic [1:0]   intr_state_o;
  logic [1:0]   intr_o;

  int errors = 0;
  int checks = 0;

  rv_timer_mc dut (
    .clk_i(clk), .rst_i(rst_i), .active_i(active_i), .prescaler_i(prescaler_i),
    .step_i(step_i), .mtime_we_i(mtime_we_i), .mtime_wdata_i(mtime_wdata_i),
    .mtime_o(mtime_o), .tick_o(tick_o), .cmp_we_i(cmp_we_i), .cmp_wdata_i(cmp_wdata_i),
    .cmp_o(cmp_o), .mode_i(mode_i), .period_i(period_i), .intr_en_i(intr_en_i),
    .intr_clr_i(intr_clr_i), .intr_state_o(intr_state_o), .intr_o(intr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst_i = 1'b1; active_i = 1'b0; prescaler_i = '0; step_i = '0;
    mtime_we_i = 1'b0; mtime_wdata_i = '0; cmp_we_i = '0; cmp_wdata_i = '0;
    mode_i = '0; period_i = '0; intr_en_i = '0; intr_clr_i = '0;
    cyc(2);
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    rst_i = 1'b1; mtime_we_i = 1'b1; mtime_wdata_i = 64'd5; cmp_we_i = 2'b11; cmp_wdata_i = 64'd7;
    cyc(1);
    checks++; if (mtime_o !== 64'd0) begin errors++; $display("FAIL reset_mtime_we_ignored: got %0d want 0", mtime_o); end
    checks++; if (cmp_o !== {ONES, ONES}) begin errors++; $display("FAIL reset_cmp: got %h want all-ones", cmp_o); end
    rst_i = 1'b0; mtime_we_i = 1'b0; cmp_we_i = '0; active_i = 1'b1; prescaler_i = 12'd0; intr_en_i = 2'b11;
    #1;
    checks++; if (intr_state_o !== 2'b00) begin errors++; $display("FAIL reset_intr_state: got %b want 00", intr_state_o); end
    checks++; if (intr_o !== 2'b00) begin errors++; $display("FAIL reset_intr_o: got %b want 00", intr_o); end
    checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL reset_tick_presc0: got %b want 1", tick_o); end
    prescaler_i = 12'd3; #1;
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick_presc3: got %b want 0", tick_o); end
  endtask

  task automatic test_prescaler;
    int ticks;
    logic pos_ok;
    logic exp_t;
    do_reset();
    prescaler_i = 12'd3; step_i = 8'd1; active_i = 1'b1;
    ticks = 0; pos_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_t = (i % 4 == 3);
      if (tick_o !== exp_t) pos_ok = 1'b0;
      if (tick_o === 1'b1) ticks++;
      cyc(1);
    end
    checks++; if (ticks != 4) begin errors++; $display("FAIL presc_tick_count: got %0d want 4", ticks); end
    checks++; if (pos_ok !== 1'b1) begin errors++; $display("FAIL presc_tick_position: got %b want 1", pos_ok); end
    checks++; if (mtime_o !== 64'd4) begin errors++; $display("FAIL presc_mtime: got %0d want 4", mtime_o); end
    prescaler_i = 12'd10; cyc(5);
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL presc_count5_no_tick: got %b want 0", tick_o); end
    prescaler_i = 12'd2; #1;
    checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL presc_lowered_tick: got %b want 1", tick_o); end
    cyc(1);
    checks++; if (mtime_o !== 64'd5 || tick_o !== 1'b0) begin errors++; $display("FAIL presc_lowered_wrap: got mtime=%0d tick=%b want 5/0", mtime_o, tick_o); end
  endtask

  task automatic test_periodic;
    do_reset();
    mode_i = 4'b0011; period_i = {64'd0, 64'd5}; cmp_we_i = 2'b01; cmp_wdata_i = 64'd10;
    cyc(1);
    cmp_we_i = '0; active_i = 1'b1; prescaler_i = '0; step_i = 8'd1;
    cyc(10);
    checks++; if (mtime_o !== 64'd10 || cmp_o[63:0] !== 64'd10 || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL per_pre_hit: got mtime=%0d cmp=%0d intr=%b want 10/10/00", mtime_o, cmp_o[63:0], intr_state_o); end
    cyc(1);
    checks++; if (cmp_o[63:0] !== 64'd15 || intr_state_o !== 2'b01) begin errors++;
      $display("FAIL per_hit10: got cmp=%0d intr=%b want 15/01", cmp_o[63:0], intr_state_o); end
    intr_en_i = 2'b01; #1;
    checks++; if (intr_o !== 2'b01) begin errors++; $display("FAIL per_intr_o_en: got %b want 01", intr_o); end
    intr_clr_i = 2'b01; cyc(1); intr_clr_i = '0;
    checks++; if (intr_state_o !== 2'b00 || mtime_o !== 64'd12) begin errors++;
      $display("FAIL per_clear: got intr=%b mtime=%0d want 00/12", intr_state_o, mtime_o); end
    cyc(3);
    checks++; if (intr_state_o !== 2'b00 || cmp_o[63:0] !== 64'd15) begin errors++;
      $display("FAIL per_pre_hit15: got intr=%b cmp=%0d want 00/15", intr_state_o, cmp_o[63:0]); end
    cyc(1);
    checks++; if (cmp_o[63:0] !== 64'd20 || intr_state_o !== 2'b01) begin errors++;
      $display("FAIL per_hit15: got cmp=%0d intr=%b want 20/01", cmp_o[63:0], intr_state_o); end
    cyc(5);
    checks++; if (cmp_o[63:0] !== 64'd25 || intr_state_o !== 2'b01 || mtime_o !== 64'd21) begin errors++;
      $display("FAIL per_hit20: got cmp=%0d intr=%b mtime=%0d want 25/01/21", cmp_o[63:0], intr_state_o, mtime_o); end
    intr_en_i = 2'b00; #1;
    checks++; if (intr_o !== 2'b00) begin errors++; $display("FAIL per_intr_o_masked: got %b want 00", intr_o); end
  endtask

  task automatic test_oneshot;
    logic seen;
    do_reset();
    mode_i = 4'b1000; cmp_we_i = 2'b10; cmp_wdata_i = 64'd4;
    cyc(1);
    cmp_we_i = '0; active_i = 1'b1; prescaler_i = '0; step_i = 8'd1;
    cyc(4);
    checks++; if (mtime_o !== 64'd4 || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL os_pre_hit: got mtime=%0d intr=%b want 4/00", mtime_o, intr_state_o); end
    cyc(1);
    checks++; if (intr_state_o !== 2'b10) begin errors++; $display("FAIL os_hit4: got %b want 10", intr_state_o); end
    intr_clr_i = 2'b10; cyc(1); intr_clr_i = '0;
    checks++; if (intr_state_o !== 2'b00) begin errors++; $display("FAIL os_clear: got %b want 00", intr_state_o); end
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (intr_state_o !== 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || mtime_o !== 64'd20) begin errors++;
      $display("FAIL os_no_reset_fire: got seen=%b mtime=%0d want 0/20", seen, mtime_o); end
    checks++; if (cmp_o[127:64] !== 64'd4) begin errors++; $display("FAIL os_cmp_kept: got %0d want 4", cmp_o[127:64]); end
    cmp_we_i = 2'b10; cmp_wdata_i = 64'd30; cyc(1); cmp_we_i = '0;
    checks++; if (cmp_o[127:64] !== 64'd30 || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL os_rearm_write: got cmp=%0d intr=%b want 30/00", cmp_o[127:64], intr_state_o); end
    cyc(9);
    checks++; if (mtime_o !== 64'd30 || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL os_pre_hit30: got mtime=%0d intr=%b want 30/00", mtime_o, intr_state_o); end
    cyc(1);
    checks++; if (intr_state_o !== 2'b10) begin errors++; $display("FAIL os_hit30: got %b want 10", intr_state_o); end
  endtask

  task automatic test_wrap;
    do_reset();
    active_i = 1'b1; prescaler_i = '0; step_i = 8'd3;
    mtime_we_i = 1'b1; mtime_wdata_i = 64'hFFFF_FFFF_FFFF_FFFE; cyc(1); mtime_we_i = 1'b0;
    checks++; if (mtime_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL wrap_load: got %h want fffffffffffffffe", mtime_o); end
    cyc(1);
    checks++; if (mtime_o !== 64'd1) begin errors++; $display("FAIL wrap_step3: got %h want 1", mtime_o); end
    mode_i = 4'b0001; step_i = 8'd1;
    mtime_we_i = 1'b1; cyc(1); mtime_we_i = 1'b0;
    cyc(1);
    checks++; if (mtime_o !== ONES || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL lvl_at_max: got mtime=%h intr=%b want ffffffffffffffff/00", mtime_o, intr_state_o); end
    step_i = 8'd3; intr_clr_i = 2'b01; cyc(1); intr_clr_i = '0;
    checks++; if (mtime_o !== 64'd2 || intr_state_o !== 2'b01) begin errors++;
      $display("FAIL lvl_set_clr_ignored: got mtime=%0d intr=%b want 2/01", mtime_o, intr_state_o); end
    cyc(1);
    checks++; if (intr_state_o !== 2'b00) begin errors++; $display("FAIL lvl_drop_after_wrap: got %b want 00", intr_state_o); end
  endtask

  task automatic test_collision;
    do_reset();
    mode_i = 4'b0011; period_i = {64'd0, 64'd100}; cmp_we_i = 2'b01; cmp_wdata_i = 64'd3;
    cyc(1);
    cmp_we_i = '0; active_i = 1'b1; prescaler_i = '0; step_i = 8'd1;
    cyc(3);
    intr_clr_i = 2'b01; cyc(1); intr_clr_i = '0;
    checks++; if (intr_state_o !== 2'b01 || cmp_o[63:0] !== 64'd103) begin errors++;
      $display("FAIL coll_set_beats_clr: got intr=%b cmp=%0d want 01/103", intr_state_o, cmp_o[63:0]); end
    period_i = {64'd0, 64'd1}; cmp_we_i = 2'b01; cmp_wdata_i = 64'd2; cyc(1);
    cmp_wdata_i = 64'd1000; cyc(1); cmp_we_i = '0;
    checks++; if (cmp_o[63:0] !== 64'd1000) begin errors++; $display("FAIL coll_write_beats_reload: got %0d want 1000", cmp_o[63:0]); end
    period_i = '0; cmp_we_i = 2'b01; cmp_wdata_i = 64'd0; cyc(1); cmp_we_i = '0;
    cyc(1);
    checks++; if (cmp_o[63:0] !== 64'd0 || intr_state_o !== 2'b01) begin errors++;
      $display("FAIL coll_period0: got cmp=%0d intr=%b want 0/01", cmp_o[63:0], intr_state_o); end
    mode_i = 4'b0000; cyc(2);
    checks++; if (intr_state_o !== 2'b01 || cmp_o[63:0] !== 64'd0) begin errors++;
      $display("FAIL off_holds: got intr=%b cmp=%0d want 01/0", intr_state_o, cmp_o[63:0]); end
    intr_clr_i = 2'b01; cyc(1); intr_clr_i = '0;
    checks++; if (intr_state_o !== 2'b00) begin errors++; $display("FAIL off_clear: got %b want 00", intr_state_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    mode_i = 4'b1111; period_i = {64'd7, 64'd7}; cmp_we_i = 2'b11; cmp_wdata_i = 64'd50;
    mtime_we_i = 1'b1; mtime_wdata_i = 64'd100; cyc(1);
    cmp_we_i = '0; mtime_we_i = 1'b0; active_i = 1'b1; prescaler_i = '0; step_i = 8'd1; intr_en_i = 2'b11;
    cyc(1);
    checks++; if (intr_state_o !== 2'b11 || cmp_o !== {64'd57, 64'd57}) begin errors++;
      $display("FAIL mid_pending: got intr=%b cmp=%h want 11/57,57", intr_state_o, cmp_o); end
    rst_i = 1'b1; cyc(1); rst_i = 1'b0;
    checks++; if (mtime_o !== 64'd0 || intr_state_o !== 2'b00 || intr_o !== 2'b00) begin errors++;
      $display("FAIL mid_reset_state: got mtime=%0d intr=%b intr_o=%b want 0/00/00", mtime_o, intr_state_o, intr_o); end
    checks++; if (cmp_o !== {ONES, ONES}) begin errors++; $display("FAIL mid_reset_cmp: got %h want all-ones", cmp_o); end
    cyc(1);
    checks++; if (mtime_o !== 64'd1 || intr_state_o !== 2'b00) begin errors++;
      $display("FAIL mid_no_hit: got mtime=%0d intr=%b want 1/00", mtime_o, intr_state_o); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_periodic();
    test_oneshot();
    test_wrap();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
